// File: rtl/dmem_ddr_bridge_if.sv
// Bus bundles for the dmem/DDR bridge: core data-memory port and ram request port.
// On the core bus the core is the master; on the ram bus the bridge is the master.
interface dmem_core_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
);
  logic              core_en;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  modport master (
    output core_en, core_we, core_addr, core_wdata,
    input  core_stall, core_rvalid, core_rdata
  );
  modport slave (
    input  core_en, core_we, core_addr, core_wdata,
    output core_stall, core_rvalid, core_rdata
  );
endinterface

interface ddr_req_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] write_data_in;
  logic              read_req;
  logic              write_req;
  logic              read_ready;
  logic              write_ready;
  logic              read_data_valid;
  logic [DATA_W-1:0] read_data_out;

  modport master (
    output addr_in, write_data_in, read_req, write_req,
    input  read_ready, write_ready, read_data_valid, read_data_out
  );
  modport slave (
    input  addr_in, write_data_in, read_req, write_req,
    output read_ready, write_ready, read_data_valid, read_data_out
  );
endinterface

// File: rtl/dmem_ddr_bridge.sv
// Core data-memory to DDR request bridge: posted-store write buffer, loads ordered
// behind buffered stores, core stalled until load data returns, sticky read timeout.
//
// state   | meaning
// IDLE    | accepting stores; a load starts here
// DRAIN   | load held while buffered stores flush to ram
// RD_REQ  | read_req asserted with latched load address
// RD_WAIT | read accepted, waiting for read_data_valid
// RD_DONE | one-cycle load completion, core_rvalid high
module dmem_ddr_bridge #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic      clk,
  input  logic      rst,
  dmem_core_if.slave core,
  ddr_req_if.master  ddr,
  output logic      err_timeout
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  wb_rd_ptr, wb_wr_ptr;
  logic [CNT_W-1:0]  wb_cnt;
  logic              wb_empty, wb_full, wb_push, wb_pop;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              rd_busy, tmo_hit, accept;

  logic              stall_c, rvalid_c, read_req_c, write_req_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign wb_empty = (wb_cnt == '0);
  assign wb_full  = (wb_cnt == CNT_W'(WB_DEPTH));
  assign rd_busy  = (state == RD_REQ) || (state == RD_WAIT);
  assign tmo_hit  = rd_busy && (tmo_cnt == '0);

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    stall_c     = 1'b0;
    rvalid_c    = 1'b0;
    read_req_c  = 1'b0;
    write_req_c = 1'b0;
    wb_push     = 1'b0;
    wb_pop      = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;

    accept      = (core.core_we && !wb_full && state == IDLE) ||
                  (!core.core_we && state == RD_DONE);
    stall_c     = core.core_en && !accept;
    wb_push     = core.core_en && core.core_we && !wb_full && (state == IDLE);
    rvalid_c    = (state == RD_DONE);
    read_req_c  = (state == RD_REQ) && !tmo_hit;
    write_req_c = !wb_empty && !rd_busy;
    wb_pop      = write_req_c && ddr.write_ready;

    if (read_req_c) begin
      addr_c = rd_addr;
    end else if (write_req_c) begin
      addr_c  = wb_addr[wb_rd_ptr];
      wdata_c = wb_data[wb_rd_ptr];
    end

    case (state)
      IDLE:    if (core.core_en && !core.core_we) state_nxt = wb_empty ? RD_REQ : DRAIN;
      // leave as the last buffered store pops so the read never overtakes it
      DRAIN:   if (wb_empty || (wb_pop && wb_cnt == CNT_W'(1))) state_nxt = RD_REQ;
      RD_REQ:  if (tmo_hit) state_nxt = RD_DONE;
               else if (ddr.read_ready) state_nxt = RD_WAIT;
      RD_WAIT: if (tmo_hit || ddr.read_data_valid) state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign core.core_stall   = stall_c;
  assign core.core_rvalid  = rvalid_c;
  assign core.core_rdata   = rdata_q;
  assign ddr.read_req      = read_req_c;
  assign ddr.write_req     = write_req_c;
  assign ddr.addr_in       = addr_c;
  assign ddr.write_data_in = wdata_c;

  always_ff @(posedge clk) begin
    if (wb_push) begin
      wb_addr[wb_wr_ptr] <= core.core_addr;
      wb_data[wb_wr_ptr] <= core.core_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wb_rd_ptr   <= '0;
      wb_wr_ptr   <= '0;
      wb_cnt      <= '0;
      rd_addr     <= '0;
      rdata_q     <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wb_push) wb_wr_ptr <= wb_wr_ptr + PTR_W'(1);
      if (wb_pop)  wb_rd_ptr <= wb_rd_ptr + PTR_W'(1);
      case ({wb_push, wb_pop})
        2'b10:   wb_cnt <= wb_cnt + CNT_W'(1);
        2'b01:   wb_cnt <= wb_cnt - CNT_W'(1);
        default: wb_cnt <= wb_cnt;
      endcase
      if (state == IDLE && core.core_en && !core.core_we) rd_addr <= core.core_addr;
      // down-counter reaches zero on the TIMEOUT-th cycle spent in RD_REQ+RD_WAIT
      if (state_nxt == RD_REQ && state != RD_REQ) begin
        tmo_cnt <= TMO_W'(TIMEOUT - 1);
      end else if (rd_busy && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end
      if (tmo_hit) begin
        rdata_q     <= '0;
        err_timeout <= 1'b1;
      end else if (state == RD_WAIT && ddr.read_data_valid) begin
        rdata_q <= ddr.read_data_out;
      end
    end
  end
endmodule

// File: tb/tb_dmem_ddr_bridge.sv
// Directed bench for dmem_ddr_bridge: reset, posted stores, full buffer,
// read-after-write ordering, read timeout and reset during a pending read.
module tb_dmem_ddr_bridge;
  localparam int ADDR_W   = 28;
  localparam int DATA_W   = 32;
  localparam int WB_DEPTH = 2;
  localparam int TMO      = 16;

  logic clk = 1'b0;
  logic rst;
  logic err_timeout;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) core_bus ();
  ddr_req_if   #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ddr_bus ();

  dmem_ddr_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core(core_bus),
    .ddr(ddr_bus),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic core_drive(input logic en, input logic we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    core_bus.core_en    = en;
    core_bus.core_we    = we;
    core_bus.core_addr  = a;
    core_bus.core_wdata = d;
  endtask

  task automatic chk_wr(input string tag, input logic req,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, ".wreq"},  64'(ddr_bus.write_req), 64'(req));
    chk({tag, ".addr"},  64'(ddr_bus.addr_in), 64'(a));
    chk({tag, ".wdata"}, 64'(ddr_bus.write_data_in), 64'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held during activity
    rst = 1'b1;
    core_drive(1'b1, 1'b1, 28'h10, 32'h55);
    ddr_bus.write_ready     = 1'b1;
    ddr_bus.read_ready      = 1'b1;
    ddr_bus.read_data_valid = 1'b1;
    ddr_bus.read_data_out   = 32'hDEAD;
    step(); step(); step();
    settle();
    chk("rst.stall_st", 64'(core_bus.core_stall), 64'h0);
    chk("rst.rvalid",   64'(core_bus.core_rvalid), 64'h0);
    chk("rst.rdata",    64'(core_bus.core_rdata), 64'h0);
    chk("rst.rreq",     64'(ddr_bus.read_req), 64'h0);
    chk_wr("rst", 1'b0, '0, '0);
    chk("rst.err",      64'(err_timeout), 64'h0);
    core_bus.core_we = 1'b0;
    settle();
    chk("rst.stall_ld", 64'(core_bus.core_stall), 64'h1);
    core_drive(1'b0, 1'b0, '0, '0);
    ddr_bus.write_ready     = 1'b0;
    ddr_bus.read_ready      = 1'b0;
    ddr_bus.read_data_valid = 1'b0;
    ddr_bus.read_data_out   = '0;
    rst = 1'b0;
    step();

    // single store
    ddr_bus.write_ready = 1'b1;
    core_drive(1'b1, 1'b1, 28'h100, 32'hCAFEBABE);
    settle();
    chk("st.stall", 64'(core_bus.core_stall), 64'h0);
    chk("st.c0_wreq", 64'(ddr_bus.write_req), 64'h0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    settle();
    chk_wr("st.c1", 1'b1, 28'h100, 32'hCAFEBABE);
    step();
    settle();
    chk_wr("st.c2", 1'b0, '0, '0);

    // buffer full: A, B accepted, C stalls until the first pop
    ddr_bus.write_ready = 1'b0;
    core_drive(1'b1, 1'b1, 28'h200, 32'hA);
    settle();
    chk("full.a_stall", 64'(core_bus.core_stall), 64'h0);
    step();
    core_drive(1'b1, 1'b1, 28'h204, 32'hB);
    settle();
    chk("full.b_stall", 64'(core_bus.core_stall), 64'h0);
    chk_wr("full.head_a", 1'b1, 28'h200, 32'hA);
    step();
    core_drive(1'b1, 1'b1, 28'h208, 32'hC);
    settle();
    chk("full.c_stall0", 64'(core_bus.core_stall), 64'h1);
    step();
    ddr_bus.write_ready = 1'b1;
    settle();
    chk("full.c_stall1", 64'(core_bus.core_stall), 64'h1);
    chk_wr("full.pop_a", 1'b1, 28'h200, 32'hA);
    step();
    settle();
    chk("full.c_accept", 64'(core_bus.core_stall), 64'h0);
    chk_wr("full.pop_b", 1'b1, 28'h204, 32'hB);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    settle();
    chk_wr("full.pop_c", 1'b1, 28'h208, 32'hC);
    step();
    settle();
    chk_wr("full.empty", 1'b0, '0, '0);
    ddr_bus.write_ready = 1'b0;

    // read-after-write ordering
    core_drive(1'b1, 1'b1, 28'h40, 32'h11);
    settle();
    chk("raw.st_stall", 64'(core_bus.core_stall), 64'h0);
    step();
    core_drive(1'b1, 1'b0, 28'h40, '0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("raw.hold_rreq",  64'(ddr_bus.read_req), 64'h0);
      chk("raw.hold_stall", 64'(core_bus.core_stall), 64'h1);
      chk_wr("raw.hold", 1'b1, 28'h40, 32'h11);
      step();
    end
    ddr_bus.write_ready = 1'b1;
    settle();
    chk("raw.pop_rreq", 64'(ddr_bus.read_req), 64'h0);
    chk_wr("raw.pop", 1'b1, 28'h40, 32'h11);
    step();
    ddr_bus.write_ready = 1'b0;
    ddr_bus.read_ready  = 1'b1;
    settle();
    chk("raw.rreq", 64'(ddr_bus.read_req), 64'h1);
    chk("raw.raddr", 64'(ddr_bus.addr_in), 64'h40);
    chk("raw.rreq_wreq", 64'(ddr_bus.write_req), 64'h0);
    step();
    ddr_bus.read_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("raw.wait_rreq",   64'(ddr_bus.read_req), 64'h0);
      chk("raw.wait_rvalid", 64'(core_bus.core_rvalid), 64'h0);
      chk("raw.wait_stall",  64'(core_bus.core_stall), 64'h1);
      step();
    end
    ddr_bus.read_data_valid = 1'b1;
    ddr_bus.read_data_out   = 32'h12345678;
    settle();
    chk("raw.rdv_rvalid", 64'(core_bus.core_rvalid), 64'h0);
    step();
    ddr_bus.read_data_valid = 1'b0;
    ddr_bus.read_data_out   = '0;
    settle();
    chk("raw.rvalid", 64'(core_bus.core_rvalid), 64'h1);
    chk("raw.rdata",  64'(core_bus.core_rdata), 64'h12345678);
    chk("raw.done_stall", 64'(core_bus.core_stall), 64'h0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    settle();
    chk("raw.rvalid_end", 64'(core_bus.core_rvalid), 64'h0);

    // read timeout
    core_drive(1'b1, 1'b0, 28'h300, '0);
    ddr_bus.read_ready = 1'b1;
    settle();
    chk("tmo.c0_stall", 64'(core_bus.core_stall), 64'h1);
    step();
    settle();
    chk("tmo.rreq",  64'(ddr_bus.read_req), 64'h1);
    chk("tmo.raddr", 64'(ddr_bus.addr_in), 64'h300);
    step();
    for (int i = 0; i < TMO - 2; i++) step();
    settle();
    chk("tmo.last_err",    64'(err_timeout), 64'h0);
    chk("tmo.last_rvalid", 64'(core_bus.core_rvalid), 64'h0);
    chk("tmo.last_stall",  64'(core_bus.core_stall), 64'h1);
    step();
    settle();
    chk("tmo.rvalid", 64'(core_bus.core_rvalid), 64'h1);
    chk("tmo.rdata",  64'(core_bus.core_rdata), 64'h0);
    chk("tmo.err",    64'(err_timeout), 64'h1);
    chk("tmo.stall",  64'(core_bus.core_stall), 64'h0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    ddr_bus.read_ready  = 1'b0;
    ddr_bus.write_ready = 1'b1;
    settle();
    chk("tmo.rvalid_end", 64'(core_bus.core_rvalid), 64'h0);
    core_drive(1'b1, 1'b1, 28'h50, 32'h77);
    settle();
    chk("tmo.st_stall", 64'(core_bus.core_stall), 64'h0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    settle();
    chk_wr("tmo.st", 1'b1, 28'h50, 32'h77);
    step();
    settle();
    chk_wr("tmo.st_done", 1'b0, '0, '0);
    chk("tmo.err_sticky", 64'(err_timeout), 64'h1);
    ddr_bus.write_ready = 1'b0;

    // reset while waiting for read data
    core_drive(1'b1, 1'b0, 28'h60, '0);
    ddr_bus.read_ready = 1'b1;
    step();
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    ddr_bus.read_ready = 1'b0;
    settle();
    chk("rstw.wait_rreq", 64'(ddr_bus.read_req), 64'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("rstw.err_clr", 64'(err_timeout), 64'h0);
    chk("rstw.rreq0",   64'(ddr_bus.read_req), 64'h0);
    step();
    ddr_bus.read_data_valid = 1'b1;
    ddr_bus.read_data_out   = 32'hBAD;
    settle();
    chk("rstw.rdv_rvalid", 64'(core_bus.core_rvalid), 64'h0);
    step();
    ddr_bus.read_data_valid = 1'b0;
    ddr_bus.read_data_out   = '0;
    settle();
    chk("rstw.rvalid", 64'(core_bus.core_rvalid), 64'h0);
    chk("rstw.rdata",  64'(core_bus.core_rdata), 64'h0);
    chk("rstw.rreq1",  64'(ddr_bus.read_req), 64'h0);
    chk("rstw.wreq",   64'(ddr_bus.write_req), 64'h0);
    core_drive(1'b1, 1'b1, 28'h70, 32'h1);
    settle();
    chk("rstw.idle_stall", 64'(core_bus.core_stall), 64'h0);
    step();
    core_drive(1'b0, 1'b0, '0, '0);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_ddr_bridge.md
# dmem_ddr_bridge

Upstream adapter between the RISC-V core's data-memory port and the `ram` DDR3 controller's request interface. It posts core stores into a small write buffer, serialises loads behind the buffered stores, and stalls the core until load data returns. It also flags controller read hangs with a timeout. It sits directly in front of `ram`: its ram-side outputs drive `addr_in`, `write_data_in`, `read_req` and `write_req`.

## Interface
- ADDR_W, 28, byte address width on both sides
- DATA_W, 32, data width on both sides
- WB_DEPTH, 2, write-buffer entries; power of two, ≥2
- TIMEOUT, 1024, cycles a read may spend in RD_REQ+RD_WAIT before abort; ≥2
- clk  in  1  sole clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- core_en  in  1  core memory access request
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  access address
- core_wdata  in  DATA_W  store data
- core_stall  out  1  core must hold the request stable
- core_rvalid  out  1  one-cycle pulse; core_rdata valid
- core_rdata  out  DATA_W  load data, registered
- addr_in  out  ADDR_W  to ram
- write_data_in  out  DATA_W  to ram
- read_req  out  1  to ram
- write_req  out  1  to ram
- read_ready  in  1  ram accepts read_req this edge
- write_ready  in  1  ram accepts write_req this edge
- read_data_valid  in  1  one-cycle pulse with read_data_out
- read_data_out  in  DATA_W  from ram
- err_timeout  out  1  sticky read-timeout flag

## Operation
- States: IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE.
- A core request is accepted on an edge where core_en=1 and core_stall=0.
- accept = (core_we & ~wb_full & state==IDLE) | (~core_we & state==RD_DONE).
- core_stall = core_en & ~accept, combinational.
- Store acceptance pushes {core_addr, core_wdata} into the FIFO. The core never stalls on a store unless the FIFO is full.
- Write drain: write_req=1 when the FIFO is non-empty and state ∉ {RD_REQ, RD_WAIT}.
  - addr_in and write_data_in show the FIFO head.
  - The FIFO pops on write_req & write_ready.
  - Entries leave in push order.
- Push while full never happens, because stall is gated by wb_full. A push and a pop in the same cycle leave the count unchanged.
- Load in IDLE (core_en & ~core_we):
  - FIFO non-empty → DRAIN.
  - FIFO empty → RD_REQ.
  - The core address is latched on entry to either state.
- DRAIN: go to RD_REQ on the cycle the FIFO becomes empty. This enforces read-after-write ordering.
- RD_REQ: read_req=1 and addr_in = latched address. Go to RD_WAIT on read_ready.
- RD_WAIT: on read_data_valid, register read_data_out into core_rdata and go to RD_DONE.
- RD_DONE: lasts one cycle. core_rvalid=1, core_stall=0 for the held load, then return to IDLE.
- read_data_valid is ignored outside RD_WAIT.
- Timeout:
  - A counter clears on entry to RD_REQ and increments in RD_REQ and RD_WAIT.
  - At count TIMEOUT-1, drop read_req, set err_timeout, load core_rdata=0 and go to RD_DONE.
- err_timeout is cleared only by rst.
- addr_in mux priority: RD_REQ latched address, else FIFO head. When nothing is requested, addr_in and write_data_in are 0.

## Timing
- On rst: state=IDLE, FIFO flushed, timeout counter 0, all outputs 0 (core_stall follows its equation with the FIFO empty).
- Store: accepted at edge c0 with no stall. write_req=1 in c1 with that entry. Popped at the c1 edge if write_ready=1.
- Load, FIFO empty, ram ready:
  - c0 present (stall=1).
  - c1 RD_REQ with read_req=1 and read_ready=1.
  - c2 RD_WAIT with read_data_valid=1.
  - c3 RD_DONE with core_rvalid=1 and stall=0.
  - Minimum load latency is 3 cycles.
- Each extra cycle of read_ready=0 or missing read_data_valid adds one cycle.
- rst mid-transaction aborts the transaction in the next cycle. No read_req or write_req is issued afterwards for the flushed entries.

## Test plan
- Reset: hold rst 3 cycles during activity → every output 0, FIFO empty, err_timeout=0.
- Single store: addr 0x100, data 0xCAFEBABE, write_ready=1 → no stall; write_req=1 for exactly one cycle at c1 with addr_in=0x100 and write_data_in=0xCAFEBABE.
- Buffer full: three back-to-back stores (A,B,C) with write_ready=0 → A and B accepted, stall on C. Raise write_ready → C accepted one cycle after the first pop; ram sees A, B, C in order.
- RAW ordering: store 0x40←0x11, then load 0x40, write_ready low for 4 cycles → read_req stays 0 until the store is popped. read_data_valid with 0x12345678 five cycles after the read accept → core_rvalid pulse with core_rdata=0x12345678.
- Timeout: load with read_ready=1 and no read_data_valid → after TIMEOUT cycles err_timeout=1, core_rvalid pulse with core_rdata=0. The next store completes normally; err_timeout stays 1.
- Reset in RD_WAIT: assert rst, then pulse read_data_valid 2 cycles later → no core_rvalid, read_req=0, state IDLE.
